// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
// Provides the occupancy-counter width function used by the interface and top.
package dff_pipe_pkg;

  // Occupancy counts 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready bus of the elastic register pipeline.
// slave: pipeline side; master: producer/consumer side.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  import dff_pipe_pkg::*;

  logic                      load;
  logic [WIDTH-1:0]          data;
  logic                      load_ready;
  logic                      q_valid;
  logic                      q_ready;
  logic [WIDTH-1:0]          Q;
  logic [WIDTH-1:0]          notQ;
  logic [occ_w(DEPTH)-1:0]   occupancy;
  logic                      parity_err;

  modport slave (
    input  load, data, q_ready,
    output load_ready, q_valid, Q, notQ,
    output occupancy, parity_err
  );

  modport master (
    output load, data, q_ready,
    input  load_ready, q_valid, Q, notQ,
    input  occupancy, parity_err
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One pipeline register: valid flag plus W-bit word, async reset.
// Ports: clk, reset, ld (slot free/advancing), in_valid/in_data, valid/q.
module dff_pipe_stage #(
  parameter int W = 8,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] q
);

  // The word only changes on a real transfer in, so a
  // drained slot keeps its last contents instead of junk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= RESET_VALUE;
    end else if (ld) begin
      valid <= in_valid;
      if (in_valid) q <= in_data;
    end
  end

endmodule

// File: rtl/dff_pipe_reg.sv
// Elastic DEPTH x WIDTH register pipeline, valid/ready both ends.
// Ports: clk, reset (async, high), bus (dff_pipe_if.slave).
// Optional DFF_PIPE_PARITY_EN: one even-parity bit per stage.
module dff_pipe_reg
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic      clk,
  input  logic      reset,
  dff_pipe_if.slave bus
);

  localparam int OW = occ_w(DEPTH);

`ifdef DFF_PIPE_PARITY_EN
  localparam int SW = WIDTH + 1;
  localparam logic [SW-1:0] SRV =
    {^RESET_VALUE, RESET_VALUE};
`else
  localparam int SW = WIDTH;
  localparam logic [SW-1:0] SRV = RESET_VALUE;
`endif

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] src_valid;
  logic [SW-1:0]    word     [DEPTH];
  logic [SW-1:0]    src_word [DEPTH];
  logic [SW-1:0]    in_word;
  logic             in_xfer;
  logic             out_xfer;
  logic [OW-1:0]    occ;

`ifdef DFF_PIPE_PARITY_EN
  assign in_word = {^bus.data, bus.data};
  assign bus.parity_err = valid[DEPTH-1] &&
    ((^word[DEPTH-1][WIDTH-1:0]) != word[DEPTH-1][WIDTH]);
`else
  assign in_word = bus.data;
  assign bus.parity_err = 1'b0;
`endif

  // Ready chain runs tail to head, purely combinational:
  // a stage may move on if the next slot is empty or moving.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = bus.q_ready;
    for (int s = DEPTH - 2; s >= 0; s--)
      adv[s] = !valid[s+1] || adv[s+1];
  end

  assign ld = ~valid | adv;

  always_comb begin
    src_valid    = '0;
    src_valid[0] = bus.load;
    src_word[0]  = in_word;
    for (int s = 1; s < DEPTH; s++) begin
      src_valid[s] = valid[s-1];
      src_word[s]  = word[s-1];
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_st
    dff_pipe_stage #(
      .W           (SW),
      .RESET_VALUE (SRV)
    ) u_st (
      .clk      (clk),
      .reset    (reset),
      .ld       (ld[s]),
      .in_valid (src_valid[s]),
      .in_data  (src_word[s]),
      .valid    (valid[s]),
      .q        (word[s])
    );
  end

  assign in_xfer  = bus.load && ld[0];
  assign out_xfer = valid[DEPTH-1] && bus.q_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else begin
      unique case ({in_xfer, out_xfer})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign bus.load_ready = ld[0];
  assign bus.q_valid    = valid[DEPTH-1];
  assign bus.Q          = word[DEPTH-1][WIDTH-1:0];
  assign bus.notQ       = ~word[DEPTH-1][WIDTH-1:0];
  assign bus.occupancy  = occ;

endmodule
